// File: rtl/l1_arbiter_if.sv
// Bundle of L1 client request/return signals and the L2 request/read channel.
// slave: the arbiter's view; master: the L1 clients and L2 side driving it.
interface l1_arbiter_if #(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4
);
   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [NUM_PORTS-1:0]        l1_req;
   logic [NUM_PORTS*ADDR_W-1:0] l1_addr;
   logic [NUM_PORTS-1:0]        l1_rnw;
   logic [NUM_PORTS*3-1:0]      l1_size;
   logic [NUM_PORTS-1:0]        l1_ack;
   logic                        l2_req;
   logic [ADDR_W-1:0]           l2_addr;
   logic                        l2_rnw;
   logic [2:0]                  l2_size;
   logic [1:0]                  l2_id;
   logic                        l2_ack;
   logic                        l2_rd_valid;
   logic [DATA_W-1:0]           l2_rd_data;
   logic [NUM_PORTS-1:0]        l1_rd_valid;
   logic [DATA_W-1:0]           l1_rd_data;
   logic                        l1_rd_last;
   logic                        spurious_rd;
   // Debug view of the read-tracking FIFO occupancy.
   logic [CNT_W-1:0]            occupancy;

   modport slave (
      input  l1_req, l1_addr, l1_rnw, l1_size, l2_ack, l2_rd_valid, l2_rd_data,
      output l1_ack, l2_req, l2_addr, l2_rnw, l2_size, l2_id,
             l1_rd_valid, l1_rd_data, l1_rd_last, spurious_rd, occupancy
   );

   modport master (
      output l1_req, l1_addr, l1_rnw, l1_size, l2_ack, l2_rd_valid, l2_rd_data,
      input  l1_ack, l2_req, l2_addr, l2_rnw, l2_size, l2_id,
             l1_rd_valid, l1_rd_data, l1_rd_last, spurious_rd, occupancy
   );
endinterface

// File: rtl/l1_arbiter.sv
// L1-to-L2 request arbiter with in-order read return routing.
// Define L1_ARB_FIXED_PRIORITY_EN for fixed priority (lowest id wins); default is round-robin.
module l1_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic         clk,
   input logic         rst_n,
   l1_arbiter_if.slave bus
);
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
   localparam int ID_W   = 2;
   localparam int BEAT_W = 6;

   // Handshake: a client holds l1_req (and its fields) until it sees a one-cycle
   // l1_ack; l2_req and its fields stay stable until the cycle L2 asserts l2_ack.

   logic [ADDR_W-1:0]    addr_arr [NUM_PORTS];
   logic [2:0]           size_arr [NUM_PORTS];
   logic [NUM_PORTS-1:0] eligible;
   logic [PORT_W-1:0]    ptr_q;
   logic [PORT_W-1:0]    winner;
   logic [PORT_W-1:0]    cand;
   logic                 grant_valid;
   logic                 grant;
   logic                 slot_free;
   logic                 fifo_full;
   logic                 push;
   logic                 pop;
   logic                 rd_hit;

   logic                 l2_req_q;
   logic [ADDR_W-1:0]    l2_addr_q;
   logic                 l2_rnw_q;
   logic [2:0]           l2_size_q;
   logic [ID_W-1:0]      l2_id_q;

   logic [ID_W-1:0]      id_mem   [MAX_OUTSTANDING];
   logic [2:0]           size_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [BEAT_W-1:0]    beat_q;
   logic [BEAT_W-1:0]    beats_m1;
   logic [ID_W-1:0]      head_id;
   logic [2:0]           head_size;
   logic                 spurious_q;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
      assign addr_arr[g] = bus.l1_addr[g*ADDR_W +: ADDR_W];
      assign size_arr[g] = bus.l1_size[g*3 +: 3];
   end

   // Fullness uses registered occupancy only, so a same-cycle pop never admits a read.
   assign fifo_full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
   assign eligible  = bus.l1_req & (~bus.l1_rnw | {NUM_PORTS{~fifo_full}});
   assign slot_free = !l2_req_q || bus.l2_ack;

   always_comb begin
      grant_valid = 1'b0;
      winner      = '0;
      cand        = '0;
`ifdef L1_ARB_FIXED_PRIORITY_EN
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         cand = PORT_W'(i);
         if (eligible[cand]) begin
            grant_valid = 1'b1;
            winner      = cand;
         end
      end
`else
      // Scan backwards so the last hit is the first eligible client after ptr_q.
      for (int off = NUM_PORTS; off >= 1; off--) begin
         cand = PORT_W'((int'(ptr_q) + off) % NUM_PORTS);
         if (eligible[cand]) begin
            grant_valid = 1'b1;
            winner      = cand;
         end
      end
`endif
   end

   assign grant = rst_n && slot_free && grant_valid;
   assign push  = grant && bus.l1_rnw[winner];

   assign head_id   = id_mem[rd_ptr_q];
   assign head_size = size_mem[rd_ptr_q];

   always_comb begin
      case (head_size)
         3'd0:    beats_m1 = 6'd0;
         3'd1:    beats_m1 = 6'd3;
         3'd2:    beats_m1 = 6'd7;
         3'd3:    beats_m1 = 6'd15;
         3'd4:    beats_m1 = 6'd31;
         default: beats_m1 = 6'd63;
      endcase
   end

   assign rd_hit = bus.l2_rd_valid && (cnt_q != '0);
   assign pop    = rd_hit && (beat_q == beats_m1);

   assign bus.l1_ack      = grant ? (NUM_PORTS'(1) << winner) : '0;
   assign bus.l2_req      = l2_req_q;
   assign bus.l2_addr     = l2_addr_q;
   assign bus.l2_rnw      = l2_rnw_q;
   assign bus.l2_size     = l2_size_q;
   assign bus.l2_id       = l2_id_q;
   assign bus.l1_rd_valid = rd_hit ? (NUM_PORTS'(1) << head_id) : '0;
   assign bus.l1_rd_data  = rd_hit ? bus.l2_rd_data : '0;
   assign bus.l1_rd_last  = pop;
   assign bus.spurious_rd = spurious_q;
   assign bus.occupancy   = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         l2_req_q   <= 1'b0;
         l2_addr_q  <= '0;
         l2_rnw_q   <= 1'b0;
         l2_size_q  <= '0;
         l2_id_q    <= '0;
         ptr_q      <= PORT_W'(NUM_PORTS - 1);
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         beat_q     <= '0;
         spurious_q <= 1'b0;
      end else begin
         if (grant) begin
            l2_req_q  <= 1'b1;
            l2_addr_q <= addr_arr[winner];
            l2_rnw_q  <= bus.l1_rnw[winner];
            l2_size_q <= size_arr[winner];
            l2_id_q   <= ID_W'(winner);
`ifndef L1_ARB_FIXED_PRIORITY_EN
            ptr_q     <= winner;
`endif
         end else if (bus.l2_ack) begin
            l2_req_q <= 1'b0;
         end
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
         if (pop)         beat_q <= '0;
         else if (rd_hit) beat_q <= beat_q + 1'b1;
         if (bus.l2_rd_valid && (cnt_q == '0)) spurious_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         id_mem[wr_ptr_q]   <= ID_W'(winner);
         size_mem[wr_ptr_q] <= size_arr[winner];
      end
   end
endmodule

// File: tb/tb_l1_arbiter.sv
// Self-checking bench for l1_arbiter: a directed vector table plus hand sequences.
// Covers L1_ARB_FIXED_PRIORITY_EN builds through the alternate vector table.
module tb_l1_arbiter;
   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   logic [DW-1:0] exp_q[$];

   l1_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) bus ();

   l1_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  rnw;
      logic        l2_ack;
      logic        rd_valid;
      logic [31:0] rd_data;
      logic [3:0]  exp_ack;
      logic        exp_l2_req;
      logic [1:0]  exp_id;
      logic [3:0]  exp_rd_valid;
      logic        exp_last;
   } vec_t;

   vec_t vecs[8];
   int   nv;

   function automatic vec_t mk(input logic [3:0] req, input logic [3:0] rnw, input logic l2_ack,
                               input logic rd_valid, input logic [31:0] rd_data,
                               input logic [3:0] exp_ack, input logic exp_l2_req,
                               input logic [1:0] exp_id, input logic [3:0] exp_rd_valid,
                               input logic exp_last);
      vec_t v;
      v.req = req; v.rnw = rnw; v.l2_ack = l2_ack; v.rd_valid = rd_valid; v.rd_data = rd_data;
      v.exp_ack = exp_ack; v.exp_l2_req = exp_l2_req; v.exp_id = exp_id;
      v.exp_rd_valid = exp_rd_valid; v.exp_last = exp_last;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic set_client(input int i, input logic req, input logic rnw, input logic [2:0] size);
      bus.l1_req[i]         = req;
      bus.l1_rnw[i]         = rnw;
      bus.l1_size[i*3 +: 3] = size;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      bus.l1_req = '0; bus.l1_rnw = '0; bus.l1_size = '0;
      for (int i = 0; i < NP; i++) bus.l1_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i) * 32'h100;
      bus.l2_ack = 1'b0; bus.l2_rd_valid = 1'b0; bus.l2_rd_data = '0;

`ifdef L1_ARB_FIXED_PRIORITY_EN
      vecs[0] = mk(4'h9, 4'h9, 1, 0, 32'h0,  4'b0001, 0, 2'd0, 4'b0000, 0);
      vecs[1] = mk(4'h9, 4'h9, 1, 1, 32'hD2, 4'b0001, 1, 2'd0, 4'b0001, 1);
      vecs[2] = mk(4'h9, 4'h9, 1, 1, 32'hD3, 4'b0001, 1, 2'd0, 4'b0001, 1);
      vecs[3] = mk(4'h8, 4'h8, 1, 1, 32'hD4, 4'b1000, 1, 2'd0, 4'b0001, 1);
      vecs[4] = mk(4'h0, 4'h0, 1, 1, 32'hD5, 4'b0000, 1, 2'd3, 4'b1000, 1);
      vecs[5] = mk(4'h0, 4'h0, 0, 0, 32'h0,  4'b0000, 0, 2'd3, 4'b0000, 0);
      nv = 6;
`else
      vecs[0] = mk(4'hF, 4'hF, 1, 0, 32'h0,  4'b0001, 0, 2'd0, 4'b0000, 0);
      vecs[1] = mk(4'hF, 4'hF, 1, 1, 32'hD2, 4'b0010, 1, 2'd0, 4'b0001, 1);
      vecs[2] = mk(4'hF, 4'hF, 1, 1, 32'hD3, 4'b0100, 1, 2'd1, 4'b0010, 1);
      vecs[3] = mk(4'hF, 4'hF, 1, 1, 32'hD4, 4'b1000, 1, 2'd2, 4'b0100, 1);
      vecs[4] = mk(4'hF, 4'hF, 1, 1, 32'hD5, 4'b0001, 1, 2'd3, 4'b1000, 1);
      vecs[5] = mk(4'h0, 4'h0, 1, 1, 32'hD6, 4'b0000, 1, 2'd0, 4'b0001, 1);
      vecs[6] = mk(4'h0, 4'h0, 0, 0, 32'h0,  4'b0000, 0, 2'd0, 4'b0000, 0);
      nv = 7;
`endif

      // Reset values with requests idle.
      repeat (2) @(posedge clk);
      #1;
      check("rst_l2_req", bus.l2_req, 0);
      check("rst_ack", bus.l1_ack, 0);
      check("rst_occupancy", bus.occupancy, 0);
      check("rst_spurious", bus.spurious_rd, 0);
      rst_n = 1'b1;

      // Table-driven arbitration and single-beat return.
      for (int k = 0; k < nv; k++) begin
         bus.l1_req = vecs[k].req;
         bus.l1_rnw = vecs[k].rnw;
         bus.l1_size = '0;
         bus.l2_ack = vecs[k].l2_ack;
         bus.l2_rd_valid = vecs[k].rd_valid;
         bus.l2_rd_data = vecs[k].rd_data;
         sample();
         check($sformatf("v%0d_ack", k), bus.l1_ack, vecs[k].exp_ack);
         check($sformatf("v%0d_l2_req", k), bus.l2_req, vecs[k].exp_l2_req);
         check($sformatf("v%0d_l2_id", k), bus.l2_id, vecs[k].exp_id);
         check($sformatf("v%0d_rd_valid", k), bus.l1_rd_valid, vecs[k].exp_rd_valid);
         check($sformatf("v%0d_rd_last", k), bus.l1_rd_last, vecs[k].exp_last);
         if (vecs[k].exp_rd_valid != 4'b0000)
            check($sformatf("v%0d_rd_data", k), bus.l1_rd_data, vecs[k].rd_data);
         tick();
      end
      bus.l1_req = '0; bus.l2_ack = 1'b0; bus.l2_rd_valid = 1'b0;

      // Client 2 read burst of 4; L2 stalls 5 cycles while client 1 waits with a write.
      bus.l1_addr[2*AW +: AW] = 32'h2000_0040;
      set_client(2, 1, 1, 3'd1);
      sample();
      check("b_grant_c2", bus.l1_ack, 4'b0100);
      tick();
      set_client(2, 0, 1, 3'd0);
      set_client(1, 1, 0, 3'd3);
      for (int c = 0; c < 5; c++) begin
         sample();
         check($sformatf("stall%0d_ack", c), bus.l1_ack, 0);
         check($sformatf("stall%0d_req", c), bus.l2_req, 1);
         check($sformatf("stall%0d_addr", c), bus.l2_addr, 32'h2000_0040);
         check($sformatf("stall%0d_size", c), bus.l2_size, 3'd1);
         check($sformatf("stall%0d_id", c), bus.l2_id, 2'd2);
         tick();
      end
      bus.l2_ack = 1'b1;
      sample();
      check("stall_release_ack_c1", bus.l1_ack, 4'b0010);
      tick();
      set_client(1, 0, 0, 3'd0);
      sample();
      check("write_l2_id", bus.l2_id, 2'd1);
      check("write_l2_rnw", bus.l2_rnw, 0);
      check("write_l2_size", bus.l2_size, 3'd3);
      tick();
      bus.l2_ack = 1'b0;
      sample();
      check("b_l2_req_cleared", bus.l2_req, 0);
      check("b_occupancy", bus.occupancy, 1);
      tick();
      exp_q = {32'hA0, 32'hA1, 32'hA2, 32'hA3};
      for (int b = 0; b < 4; b++) begin
         bus.l2_rd_valid = 1'b1;
         bus.l2_rd_data = 32'hA0 + 32'(b);
         sample();
         check($sformatf("beat%0d_valid", b), bus.l1_rd_valid, 4'b0100);
         check($sformatf("beat%0d_data", b), bus.l1_rd_data, exp_q.pop_front());
         check($sformatf("beat%0d_last", b), bus.l1_rd_last, (b == 3));
         tick();
      end
      bus.l2_rd_valid = 1'b0;
      sample();
      check("b_fifo_empty", bus.occupancy, 0);
      tick();

      // Fill the FIFO with client 3 reads, then check read blocking and write bypass.
      bus.l2_ack = 1'b1;
      set_client(3, 1, 1, 3'd0);
      for (int k = 0; k < 4; k++) begin
         sample();
         check($sformatf("fill%0d_ack", k), bus.l1_ack, 4'b1000);
         tick();
      end
      set_client(3, 0, 1, 3'd0);
      set_client(0, 1, 1, 3'd0);
      set_client(1, 1, 0, 3'd0);
      sample();
      check("full_occupancy", bus.occupancy, 4);
      check("full_write_granted", bus.l1_ack, 4'b0010);
      tick();
      set_client(1, 0, 0, 3'd0);
      bus.l2_rd_valid = 1'b1;
      bus.l2_rd_data = 32'hB0;
      sample();
      check("full_pop_no_bypass", bus.l1_ack, 0);
      check("full_pop_valid", bus.l1_rd_valid, 4'b1000);
      check("full_pop_last", bus.l1_rd_last, 1);
      tick();
      bus.l2_rd_valid = 1'b0;
      sample();
      check("granted_after_pop", bus.l1_ack, 4'b0001);
      check("after_pop_occupancy", bus.occupancy, 3);
      tick();
      set_client(0, 0, 1, 3'd0);
      sample();
      check("refill_occupancy", bus.occupancy, 4);
      tick();
      bus.l2_ack = 1'b0;
      for (int b = 0; b < 4; b++) begin
         bus.l2_rd_valid = 1'b1;
         bus.l2_rd_data = 32'hC0 + 32'(b);
         sample();
         check($sformatf("drain%0d_valid", b), bus.l1_rd_valid, (b < 3) ? 4'b1000 : 4'b0001);
         check($sformatf("drain%0d_last", b), bus.l1_rd_last, 1);
         tick();
      end
      bus.l2_rd_valid = 1'b0;

      // Spurious read beat with nothing outstanding.
      sample();
      check("spurious_before", bus.spurious_rd, 0);
      tick();
      bus.l2_rd_valid = 1'b1;
      bus.l2_rd_data = 32'hEE;
      sample();
      check("spurious_no_valid", bus.l1_rd_valid, 0);
      check("spurious_no_last", bus.l1_rd_last, 0);
      tick();
      bus.l2_rd_valid = 1'b0;
      sample();
      check("spurious_set", bus.spurious_rd, 1);
      tick();
      sample();
      check("spurious_sticky", bus.spurious_rd, 1);
      tick();

      // Reset in the middle of an 8-beat burst, then a fresh read routes correctly.
      bus.l2_ack = 1'b1;
      set_client(0, 1, 1, 3'd2);
      sample();
      check("r_grant_c0", bus.l1_ack, 4'b0001);
      tick();
      set_client(0, 0, 1, 3'd0);
      tick();
      bus.l2_ack = 1'b0;
      for (int b = 0; b < 3; b++) begin
         bus.l2_rd_valid = 1'b1;
         bus.l2_rd_data = 32'hD0 + 32'(b);
         sample();
         check($sformatf("r_beat%0d_valid", b), bus.l1_rd_valid, 4'b0001);
         check($sformatf("r_beat%0d_last", b), bus.l1_rd_last, 0);
         tick();
      end
      set_client(1, 1, 1, 3'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ack", bus.l1_ack, 0);
      check("mid_rst_l2_req", bus.l2_req, 0);
      check("mid_rst_l2_addr", bus.l2_addr, 0);
      check("mid_rst_l2_size", bus.l2_size, 0);
      check("mid_rst_l2_id", bus.l2_id, 0);
      check("mid_rst_rd_valid", bus.l1_rd_valid, 0);
      check("mid_rst_rd_data", bus.l1_rd_data, 0);
      check("mid_rst_rd_last", bus.l1_rd_last, 0);
      check("mid_rst_spurious", bus.spurious_rd, 0);
      check("mid_rst_occupancy", bus.occupancy, 0);
      tick();
      rst_n = 1'b1;
      bus.l2_rd_valid = 1'b0;
      sample();
      check("post_rst_grant_c1", bus.l1_ack, 4'b0010);
      tick();
      set_client(1, 0, 1, 3'd0);
      bus.l2_ack = 1'b1;
      sample();
      check("post_rst_l2_id", bus.l2_id, 2'd1);
      check("post_rst_l2_addr", bus.l2_addr, 32'h1000_0100);
      tick();
      bus.l2_ack = 1'b0;
      bus.l2_rd_valid = 1'b1;
      bus.l2_rd_data = 32'h5A;
      sample();
      check("post_rst_rd_valid", bus.l1_rd_valid, 4'b0010);
      check("post_rst_rd_data", bus.l1_rd_data, 32'h5A);
      check("post_rst_rd_last", bus.l1_rd_last, 1);
      tick();
      bus.l2_rd_valid = 1'b0;
      sample();
      check("post_rst_empty", bus.occupancy, 0);
      check("post_rst_spurious", bus.spurious_rd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/l1_arbiter.md
Name: l1_arbiter

Overview:
- Arbitrates the four L1 clients (dcache id 0, dmmu id 1, icache id 2, immu id 3) onto the single L2 request channel.
- Presents one registered request at a time to L2, tagged with a 2-bit client id and a 3-bit burst-size code.
- Tracks outstanding reads in order and routes returning read beats back to the issuing client.
- Sits between the L1 caches/MMUs and the L2/bus interface.

Parameters:
NUM_PORTS, 4, number of L1 clients (ids 0..NUM_PORTS-1)
ADDR_W, 32, request address width
DATA_W, 32, read data width
MAX_OUTSTANDING, 4, depth of in-order read tracking FIFO (power of 2)

Ports:
clk  in  1  clock
rst_n  in  1  reset
l1_req  in  NUM_PORTS  per-client request valid, held until acked
l1_addr  in  NUM_PORTS*ADDR_W  per-client address, client i at [i*ADDR_W +: ADDR_W]
l1_rnw  in  NUM_PORTS  per-client 1=read 0=write
l1_size  in  NUM_PORTS*3  per-client burst code (0:1, 1:4, 2:8, 3:16, 4:32, 5:64 beats)
l1_ack  out  NUM_PORTS  one-cycle grant pulse to selected client
l2_req  out  1  registered request valid
l2_addr  out  ADDR_W  registered address
l2_rnw  out  1  registered read/write
l2_size  out  3  registered burst code
l2_id  out  2  registered client id
l2_ack  in  1  L2 accepts current request this cycle
l2_rd_valid  in  1  read beat valid
l2_rd_data  in  DATA_W  read beat data
l1_rd_valid  out  NUM_PORTS  one-hot beat valid to owning client
l1_rd_data  out  DATA_W  beat data, shared by all clients
l1_rd_last  out  1  final beat of current burst
spurious_rd  out  1  sticky flag: read beat arrived with no read outstanding

Behaviour:
- Reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low. While low, all outputs 0. Round-robin pointer resets to NUM_PORTS-1, so client 0 has first priority. Tracking FIFO empties and beat counter clears.
- Output slot free = !l2_req || l2_ack.
- Eligible client i: l1_req[i] and (l1_rnw[i]==0 or FIFO not full).
- When the slot is free and at least one client is eligible:
  - Pick the first eligible client searching from pointer+1, wrapping modulo NUM_PORTS.
  - Pulse l1_ack[winner] in the same cycle (combinational from the registered state and inputs).
  - Load l2_addr/rnw/size/id from the winner and set l2_req=1 at the next edge.
  - Update pointer to the winner.
- Back-to-back requests: one request per cycle when L2 acks every cycle.
- If l2_ack is asserted with no eligible client, l2_req clears next edge.
- l2_req fields are stable from assertion until l2_ack.
- Read push: on grant of a read, push {id, size} into the FIFO at the same edge.
- FIFO full is evaluated from registered occupancy only; a pop in the same cycle does not free a slot for that cycle's grant. No bypass.
- Burst length: beats = 1 when code==0, else 2^(code+1). Codes 6 and 7 are reserved and treated as 64.
- Return path:
  - On l2_rd_valid with FIFO non-empty: l1_rd_valid[head.id]=1 combinationally, l1_rd_data=l2_rd_data, beat counter increments.
  - On the beat where counter == beats-1: l1_rd_last=1, pop FIFO, clear counter.
  - Zero added latency.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
- l2_rd_valid with FIFO empty: beat dropped, no l1_rd_valid, spurious_rd set. It clears only on reset.
- Reset mid-burst: all tracking is discarded and the arbiter returns to the empty state.
- Writes are fire-and-forget; no tracking entry.

Optional Feature:
L1_ARB_FIXED_PRIORITY_EN
- Defined: fixed priority, lowest eligible id wins (dcache > dmmu > icache > immu); the pointer is unused and held at reset value.
- Undefined: round-robin as above.
- Return path identical in both.

Test Plan:
- All four clients request reads (size 0) continuously, l2_ack=1 every cycle -> grants in order 0,1,2,3,0; l2_id sequence matches; one l1_ack pulse per cycle.
- Client 2 read, size code 1, addr 0x20000040, then 4 beats 0xA0..0xA3 -> l1_rd_valid[2] on 4 cycles, data in order, l1_rd_last only on beat 0xA3, FIFO empty after.
- Issue 4 reads with no return beats -> FIFO full; client 0 read blocked (no ack); client 1 write (rnw=0) still granted. Return one single-beat burst -> client 0 granted the cycle after the pop.
- l2_ack held 0 for 5 cycles with l2_req=1 -> l2_addr/size/id unchanged; no further l1_ack until l2_ack.
- l2_rd_valid with nothing outstanding -> no l1_rd_valid, spurious_rd=1 and sticky. Assert rst_n=0 mid 8-beat burst -> all outputs 0 immediately; next read routes correctly.
- With L1_ARB_FIXED_PRIORITY_EN, clients 0 and 3 requesting continuously with l2_ack=1 -> client 0 granted every cycle; client 3 starves until client 0 drops its request.
